// File: rtl/mux_pkg.sv
// Shared constants for the 2:1 multiplexer family: select encodings and reset value.
package mux_pkg;

    localparam logic SEL_A       = 1'b0;
    localparam logic SEL_B       = 1'b1;
    // Single-bit seed; users replicate it to their own width.
    localparam logic MUX_RST_VAL = 1'b0;

endpackage : mux_pkg

// File: rtl/mux2_core.sv
// Combinational WIDTH-wide 2:1 selector: sel=SEL_A passes a, sel=SEL_B passes b.
module mux2_core
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves y unassigned (no latch).
        y = a;
        case (sel)
            SEL_A:   y = a;
            SEL_B:   y = b;
            default: y = a;
        endcase
    end

endmodule : mux2_core

// File: rtl/mux_2_to_1.sv
// Width-parameterised 2:1 mux with valid qualifier; OUT_REG picks a 1-cycle registered
// output or a purely combinational one.
module mux_2_to_1
    import mux_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{MUX_RST_VAL}};

    logic [WIDTH-1:0] y_next;

    mux2_core #(.WIDTH(WIDTH)) u_core (
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (y_next)
    );

    generate
        if (OUT_REG) begin : g_reg
            // Data holds on idle cycles; only the valid flag drops.
            always_ff @(posedge clk) begin
                // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
                if (!rst_n) begin
                    y         <= RST_VAL;
                    out_valid <= 1'b0;
                end else if (in_valid) begin
                    y         <= y_next;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end else begin : g_comb
            assign y         = y_next;
            assign out_valid = in_valid;
        end
    endgenerate

    // An unknown select on a qualified beat has no defined result.
    sel_known_a : assert property (@(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown(sel))
        else $error("mux_2_to_1: sel is X/Z on a valid beat");

endmodule : mux_2_to_1

// File: tb/tb_mux_2_to_1.sv
// Self-checking bench: directed reset/truth/hold/comb steps then random traffic,
// checked against an arithmetic reference of the select rule.
module tb_mux_2_to_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, s1, v1;
    logic [7:0] a8, b8;
    logic       s8, v8;

    logic       y1, ov1;
    logic [7:0] y8, yc;
    logic       ov8, ovc;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_y1, exp_y8;
    logic       exp_v1, exp_v8;

    always #5 clk = ~clk;

    mux_2_to_1 #(.WIDTH(1), .OUT_REG(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(s1), .in_valid(v1),
        .y(y1), .out_valid(ov1)
    );

    mux_2_to_1 #(.WIDTH(8), .OUT_REG(1'b1)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(s8), .in_valid(v8),
        .y(y8), .out_valid(ov8)
    );

    mux_2_to_1 #(.WIDTH(8), .OUT_REG(1'b0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(s8), .in_valid(v8),
        .y(yc), .out_valid(ovc)
    );

    // Reference select: a + sel*(b-a) lands on a or b exactly.
    function automatic logic [7:0] ref_sel(input logic [7:0] a, input logic [7:0] b, input logic s);
        int r;
        r = int'(a) + int'(s) * (int'(b) - int'(a));
        return 8'(r);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one edge, update the model from the sampled inputs, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            exp_y1 = 8'h00; exp_v1 = 1'b0;
            exp_y8 = 8'h00; exp_v8 = 1'b0;
        end else begin
            exp_v1 = v1;
            exp_v8 = v8;
            if (v1) exp_y1 = ref_sel({7'b0, a1}, {7'b0, b1}, s1);
            if (v8) exp_y8 = ref_sel(a8, b8, s8);
        end
        #1;
        check({tag, ".y1"},  {7'b0, y1}, exp_y1);
        check({tag, ".v1"},  {7'b0, ov1}, {7'b0, exp_v1});
        check({tag, ".y8"},  y8, exp_y8);
        check({tag, ".v8"},  {7'b0, ov8}, {7'b0, exp_v8});
        check({tag, ".yc"},  yc, ref_sel(a8, b8, s8));
        check({tag, ".vc"},  {7'b0, ovc}, {7'b0, v8});
    endtask

    initial begin
        logic [2:0] tt [6];
        logic [1:0] wsel;
        exp_y1 = 8'h00; exp_v1 = 1'b0;
        exp_y8 = 8'h00; exp_v8 = 1'b0;

        // Reset held over two edges with a live valid beat on the inputs.
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; s1 = 1'b1; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'h77; s8 = 1'b1; v8 = 1'b1;
        tick("rst0");
        tick("rst1");
        check("rst.y1_zero", {7'b0, y1}, 8'h00);
        check("rst.y8_zero", y8, 8'h00);

        // Truth table, {a,b,sel} rows on consecutive edges.
        rst_n = 1'b1;
        tt[0] = 3'b000; tt[1] = 3'b010; tt[2] = 3'b101;
        tt[3] = 3'b111; tt[4] = 3'b100; tt[5] = 3'b011;
        for (int i = 0; i < 6; i++) begin
            {a1, b1, s1} = tt[i];
            v1 = 1'b1;
            tick($sformatf("tt%0d", i));
        end
        check("tt.last_is_1", {7'b0, y1}, 8'h01);

        // Wide select, sel toggling every cycle.
        a8 = 8'hA5; b8 = 8'h3C; v8 = 1'b1;
        wsel = 2'b01;
        for (int i = 0; i < 4; i++) begin
            s8 = (i % 2 == 1);
            tick($sformatf("wide%0d", i));
        end
        check("wide.y8_3c", y8, 8'h3C);

        // Hold: valid low while data and select wander.
        v8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            tick($sformatf("hold%0d", i));
            check("hold.y8", y8, 8'h3C);
        end

        // Reset mid-stream discards the beat sampled alongside it.
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b0; v1 = 1'b1; rst_n = 1'b0;
        tick("midrst");
        check("midrst.y1", {7'b0, y1}, 8'h00);
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b1; s1 = 1'b1;
        tick("postrst");
        check("postrst.y1", {7'b0, y1}, 8'h01);

        // Combinational mode: select change mid-cycle, no edge in between.
        a8 = 8'h00; b8 = 8'h01; s8 = 1'b0; v8 = 1'b1;
        #1;
        check("comb.sel0", yc, 8'h00);
        s8 = 1'b1;
        #1;
        check("comb.sel1", yc, 8'h01);
        v8 = 1'b0;
        #1;
        check("comb.vlow", {7'b0, ovc}, 8'h00);
        v8 = 1'b1;
        #1;
        check("comb.vhigh", {7'b0, ovc}, 8'h01);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 15) != 0);
            a1 = 1'($urandom); b1 = 1'($urandom); s1 = 1'($urandom);
            v1 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            v8 = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_2_to_1
